// File: rtl/universal_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, rotate, parallel load,
// synchronous clear and a saturating count of valid stages.
module universal_shift_reg #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic                         en,
   input  logic [2:0]                   mode,
   input  logic [WIDTH-1:0]             sin_up,
   input  logic [WIDTH-1:0]             sin_dn,
   input  logic [DEPTH*WIDTH-1:0]       pin,
   output logic [DEPTH*WIDTH-1:0]       q,
   output logic [WIDTH-1:0]             sout_up,
   output logic [WIDTH-1:0]             sout_dn,
   output logic [$clog2(DEPTH+1)-1:0]   fill,
   output logic                         full
);

   localparam int FW = $clog2(DEPTH+1);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_SHU  = 3'b001,
      M_SHD  = 3'b010,
      M_ROU  = 3'b011,
      M_ROD  = 3'b100,
      M_LOAD = 3'b101,
      M_CLR  = 3'b110,
      M_RSV  = 3'b111
   } mode_e;

   logic [WIDTH-1:0] stg_p0     [DEPTH];
   logic [WIDTH-1:0] stg_nxt    [DEPTH];
   logic [FW-1:0]    fill_nxt;

   function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
      if (v == FW'(DEPTH)) return v;
      return v + 1'b1;
   endfunction

   always_comb begin
      stg_nxt  = stg_p0;
      fill_nxt = fill;
      case (mode_e'(mode))
         M_SHU: begin
            stg_nxt[0] = sin_up;
            for (int i = 1; i < DEPTH; i++) stg_nxt[i] = stg_p0[i-1];
            fill_nxt = sat_inc(fill);
         end
         M_SHD: begin
            for (int i = 0; i < DEPTH-1; i++) stg_nxt[i] = stg_p0[i+1];
            stg_nxt[DEPTH-1] = sin_dn;
            fill_nxt = sat_inc(fill);
         end
         M_ROU: begin
            stg_nxt[0] = stg_p0[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) stg_nxt[i] = stg_p0[i-1];
         end
         M_ROD: begin
            for (int i = 0; i < DEPTH-1; i++) stg_nxt[i] = stg_p0[i+1];
            stg_nxt[DEPTH-1] = stg_p0[0];
         end
         M_LOAD: begin
            for (int i = 0; i < DEPTH; i++) stg_nxt[i] = pin[i*WIDTH +: WIDTH];
            fill_nxt = FW'(DEPTH);
         end
         M_CLR: begin
            for (int i = 0; i < DEPTH; i++) stg_nxt[i] = '0;
            fill_nxt = '0;
         end
         default: ;
      endcase
   end

   // Stage register: full is registered from the next fill so it lines up with fill
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         stg_p0 <= '{default: '0};
         fill   <= '0;
         full   <= 1'b0;
      end else if (en) begin
         stg_p0 <= stg_nxt;
         fill   <= fill_nxt;
         full   <= (fill_nxt == FW'(DEPTH));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_pack
      assign q[g*WIDTH +: WIDTH] = stg_p0[g];
   end

   assign sout_up = stg_p0[DEPTH-1];
   assign sout_dn = stg_p0[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8, DEPTH=4): directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_universal_shift_reg;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int FW    = $clog2(DEPTH+1);

   logic                   clk = 1'b0;
   logic                   clear;
   logic                   en;
   logic [2:0]             mode;
   logic [WIDTH-1:0]       sin_up;
   logic [WIDTH-1:0]       sin_dn;
   logic [DEPTH*WIDTH-1:0] pin;
   logic [DEPTH*WIDTH-1:0] q;
   logic [WIDTH-1:0]       sout_up;
   logic [WIDTH-1:0]       sout_dn;
   logic [FW-1:0]          fill;
   logic                   full;

   int checks = 0;
   int errors = 0;

   // Reference model: m[0] is stage 0, m[DEPTH-1] is stage DEPTH-1
   logic [7:0] m[$];
   int         mfill;

   universal_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .clear(clear), .en(en), .mode(mode),
      .sin_up(sin_up), .sin_dn(sin_dn), .pin(pin),
      .q(q), .sout_up(sout_up), .sout_dn(sout_dn), .fill(fill), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        e;
      logic [2:0]  md;
      logic [7:0]  su;
      logic [7:0]  sd;
      logic [31:0] p;
      logic [31:0] xq;
      int          xfill;
   } vec_t;

   vec_t tbl[21];

   task automatic model_reset();
      m = {8'h00, 8'h00, 8'h00, 8'h00};
      mfill = 0;
   endtask

   task automatic model_apply(input logic e, input logic [2:0] md, input logic [7:0] su,
                              input logic [7:0] sd, input logic [31:0] p);
      logic [7:0] t;
      if (!e) return;
      case (md)
         3'd1: begin t = m.pop_back();  m.push_front(su); mfill = (mfill < DEPTH) ? mfill + 1 : DEPTH; end
         3'd2: begin t = m.pop_front(); m.push_back(sd);  mfill = (mfill < DEPTH) ? mfill + 1 : DEPTH; end
         3'd3: begin t = m.pop_back();  m.push_front(t); end
         3'd4: begin t = m.pop_front(); m.push_back(t); end
         3'd5: begin for (int i = 0; i < DEPTH; i++) m[i] = p[i*8 +: 8]; mfill = DEPTH; end
         3'd6: model_reset();
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_q();
      logic [31:0] r;
      for (int i = 0; i < DEPTH; i++) r[i*8 +: 8] = m[i];
      return r;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [31:0] mq;
      int          mf;
      mq = model_q();
      mf = mfill;
      cmp({name, "_q"},    {32'h0, q}, {32'h0, mq});
      cmp({name, "_sout"}, {48'h0, sout_up, sout_dn}, {48'h0, mq[31:24], mq[7:0]});
      cmp({name, "_fill"}, {60'h0, full, fill}, {60'h0, (mf == DEPTH), 3'(mf)});
   endtask

   task automatic step(input logic e, input logic [2:0] md, input logic [7:0] su,
                       input logic [7:0] sd, input logic [31:0] p);
      @(negedge clk);
      en = e; mode = md; sin_up = su; sin_dn = sd; pin = p;
      @(posedge clk);
      model_apply(e, md, su, sd, p);
      #1;
   endtask

   // Pulse clear while clk is low and en is off; outputs must drop before any edge
   task automatic async_reset(input string name);
      @(negedge clk);
      en = 1'b0;
      #2 clear = 1'b0;
      #1;
      model_reset();
      cmp({name, "_q"},    {32'h0, q}, 64'h0);
      cmp({name, "_fill"}, {60'h0, full, fill}, 64'h0);
      #1 clear = 1'b1;
   endtask

   initial begin
      logic [31:0] x;
      clear = 1'b0; en = 1'b0; mode = 3'd0; sin_up = '0; sin_dn = '0; pin = '0;
      model_reset();

      tbl[0]  = '{1'b1, 3'd1, 8'h11, 8'h00, 32'h0,        32'h00000011, 1};
      tbl[1]  = '{1'b1, 3'd1, 8'h22, 8'h00, 32'h0,        32'h00001122, 2};
      tbl[2]  = '{1'b1, 3'd1, 8'h33, 8'h00, 32'h0,        32'h00112233, 3};
      tbl[3]  = '{1'b1, 3'd1, 8'h44, 8'h00, 32'h0,        32'h11223344, 4};
      tbl[4]  = '{1'b1, 3'd1, 8'h55, 8'h00, 32'h0,        32'h22334455, 4};
      tbl[5]  = '{1'b1, 3'd5, 8'h00, 8'h00, 32'hD4C3B2A1, 32'hD4C3B2A1, 4};
      tbl[6]  = '{1'b1, 3'd3, 8'h00, 8'h00, 32'h0,        32'hC3B2A1D4, 4};
      tbl[7]  = '{1'b1, 3'd3, 8'h00, 8'h00, 32'h0,        32'hB2A1D4C3, 4};
      tbl[8]  = '{1'b1, 3'd3, 8'h00, 8'h00, 32'h0,        32'hA1D4C3B2, 4};
      tbl[9]  = '{1'b1, 3'd3, 8'h00, 8'h00, 32'h0,        32'hD4C3B2A1, 4};
      tbl[10] = '{1'b1, 3'd4, 8'h00, 8'h00, 32'h0,        32'hA1D4C3B2, 4};
      tbl[11] = '{1'b1, 3'd5, 8'h00, 8'h00, 32'hD4C3B2A1, 32'hD4C3B2A1, 4};
      tbl[12] = '{1'b1, 3'd2, 8'h00, 8'hEE, 32'h0,        32'hEED4C3B2, 4};
      tbl[13] = '{1'b0, 3'd6, 8'h00, 8'h00, 32'h0,        32'hEED4C3B2, 4};
      tbl[14] = '{1'b1, 3'd7, 8'h99, 8'h99, 32'h0,        32'hEED4C3B2, 4};
      tbl[15] = '{1'b1, 3'd6, 8'h00, 8'h00, 32'h0,        32'h00000000, 0};
      tbl[16] = '{1'b1, 3'd1, 8'h01, 8'h00, 32'h0,        32'h00000001, 1};
      tbl[17] = '{1'b1, 3'd2, 8'h00, 8'h02, 32'h0,        32'h02000000, 2};
      tbl[18] = '{1'b1, 3'd1, 8'h03, 8'h00, 32'h0,        32'h00000003, 3};
      tbl[19] = '{1'b1, 3'd2, 8'h00, 8'h04, 32'h0,        32'h04000000, 4};
      tbl[20] = '{1'b1, 3'd1, 8'h05, 8'h00, 32'h0,        32'h00000005, 4};

      #12;
      cmp("reset_q",    {32'h0, q}, 64'h0);
      cmp("reset_sout", {48'h0, sout_up, sout_dn}, 64'h0);
      cmp("reset_fill", {60'h0, full, fill}, 64'h0);
      @(negedge clk);
      clear = 1'b1;

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].e, tbl[i].md, tbl[i].su, tbl[i].sd, tbl[i].p);
         x = tbl[i].xq;
         cmp($sformatf("vec%0d_q", i),    {32'h0, q}, {32'h0, x});
         cmp($sformatf("vec%0d_sout", i), {48'h0, sout_up, sout_dn}, {48'h0, x[31:24], x[7:0]});
         cmp($sformatf("vec%0d_fill", i), {60'h0, full, fill},
             {60'h0, (tbl[i].xfill == DEPTH), 3'(tbl[i].xfill)});
      end

      // Two values in, then hold and disabled clear must change nothing
      step(1'b1, 3'd6, 8'h00, 8'h00, 32'h0);
      step(1'b1, 3'd1, 8'hAA, 8'h00, 32'h0);
      step(1'b1, 3'd1, 8'hBB, 8'h00, 32'h0);
      step(1'b1, 3'd0, 8'h12, 8'h34, 32'h0);
      cmp("hold_q", {32'h0, q}, {32'h0, 32'h0000AABB});
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd6, 8'h00, 8'h00, 32'h0);
         cmp($sformatf("en0_q%0d", i),    {32'h0, q}, {32'h0, 32'h0000AABB});
         cmp($sformatf("en0_fill%0d", i), {60'h0, full, fill}, {60'h0, 4'h2});
      end
      step(1'b1, 3'd6, 8'h00, 8'h00, 32'h0);
      cmp("sclr_q",    {32'h0, q}, 64'h0);
      cmp("sclr_fill", {60'h0, full, fill}, 64'h0);

      // A marker reaches sout_up after exactly DEPTH shift-up edges, despite gaps
      step(1'b1, 3'd1, 8'h5A, 8'h00, 32'h0);
      step(1'b0, 3'd1, 8'hFF, 8'h00, 32'h0);
      step(1'b1, 3'd1, 8'h00, 8'h00, 32'h0);
      step(1'b1, 3'd7, 8'hFF, 8'h00, 32'h0);
      step(1'b1, 3'd1, 8'h00, 8'h00, 32'h0);
      cmp("lat_early", {56'h0, sout_up}, 64'h0);
      step(1'b1, 3'd1, 8'h00, 8'h00, 32'h0);
      cmp("lat_sout_up", {56'h0, sout_up}, {56'h0, 8'h5A});

      // Async clear between edges after a load
      step(1'b1, 3'd5, 8'h00, 8'h00, 32'hD4C3B2A1);
      async_reset("aclr");
      step(1'b1, 3'd1, 8'h7F, 8'h00, 32'h0);
      cmp("aclr_after_q",    {32'h0, q}, {32'h0, 32'h0000007F});
      cmp("aclr_after_fill", {60'h0, full, fill}, {60'h0, 4'h1});

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset($sformatf("rnd_aclr%0d", n));
         end else begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 8'($urandom), 32'($urandom));
            check_model($sformatf("rnd%0d", n));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 1, giving the bits per stage (legal range 1 or more).
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of stages (legal range 2 or more).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: operation enable; when 0, all state holds.
REQ-006 SHALL have port mode, input, 3 bits: operation select per REQ-016.
REQ-007 SHALL have port sin_up, input, WIDTH bits: serial input entering stage 0.
REQ-008 SHALL have port sin_dn, input, WIDTH bits: serial input entering stage DEPTH-1.
REQ-009 SHALL have port pin, input, DEPTH*WIDTH bits: parallel load data; stage i is pin[i*WIDTH +: WIDTH].
REQ-010 SHALL have port q, output, DEPTH*WIDTH bits: all stages, packed as pin.
REQ-011 SHALL have port sout_up, output, WIDTH bits: stage DEPTH-1.
REQ-012 SHALL have port sout_dn, output, WIDTH bits: stage 0.
REQ-013 SHALL have port fill, output, $clog2(DEPTH+1) bits: count of valid stages.
REQ-014 SHALL have port full, output, 1 bit: high when fill equals DEPTH.

Function
REQ-015 Stage registers, fill and all outputs SHALL update only on the rising edge of clk, and only when en=1 and clear=1.
REQ-016 mode decode SHALL be as follows:
- 000: hold.
- 001: shift up; stage0<=sin_up, stage i<=stage i-1.
- 010: shift down; stage DEPTH-1<=sin_dn, stage i<=stage i+1.
- 011: rotate up; stage0<=stage DEPTH-1.
- 100: rotate down; stage DEPTH-1<=stage0.
- 101: parallel load from pin.
- 110: synchronous clear; all stages 0, fill 0.
- 111: hold (reserved).
REQ-017 In shift-up mode, a value on sin_up SHALL appear on sout_up after exactly DEPTH enabled shift-up edges; gaps with en=0 or hold modes SHALL NOT lose data.
REQ-018 sout_up, sout_dn and q SHALL be driven directly from the stage registers, with no combinational path from any input.
REQ-019 fill update SHALL follow these rules:
- Shift up or down: fill+1, saturating at DEPTH.
- Rotate: unchanged.
- Load: DEPTH.
- Sync clear: 0.
- Hold: unchanged.
REQ-020 fill SHALL never exceed DEPTH or wrap; a shift when full SHALL leave fill at DEPTH and discard the outgoing stage.
REQ-021 full SHALL be a registered output equal to (fill==DEPTH), valid in the same cycle as fill.
REQ-022 Rotate SHALL preserve the multiset of stage values; DEPTH consecutive rotates in one direction SHALL restore the original q.
REQ-023 Mixed direction shifts SHALL be legal on consecutive cycles, with no bubble required.
REQ-024 When en=0, any mode value including 110 SHALL have no effect.

Reset
REQ-025 While clear=0, all stages, fill and full SHALL be forced to 0 immediately, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all stored data; the first enabled edge after clear releases SHALL operate on all-zero state.
REQ-027 Outputs after reset SHALL be: q=0, sout_up=0, sout_dn=0, fill=0, full=0.

Verification (WIDTH=8, DEPTH=4)
REQ-028 The bench SHALL cover these directed scenarios:
- Reset, then shift up sin_up=11,22,33,44 on 4 edges -> q stages0..3=44,33,22,11, sout_up=11, fill=4, full=1. Fifth shift with 55 -> sout_up=22, fill stays 4.
- Load pin stages0..3=A1,B2,C3,D4, then 3 rotate-up edges -> stages=B2,C3,D4,A1. Fourth rotate -> original values, fill=4 throughout.
- Load as above, then shift down with sin_dn=EE -> stages=B2,C3,D4,EE, sout_dn=B2, fill=4.
- Shift up 2 values, hold mode and en=0 with mode=110 for 3 cycles -> q and fill(=2) unchanged. Then mode=110 with en=1 -> q=0, fill=0.
- Assert clear low between clock edges after loading -> q, fill and full read 0 before the next edge. Release, then shift up 7F -> stage0=7F, fill=1.
- Alternate shift up and shift down on successive edges -> no lost cycle, and fill increments each edge to saturation.
